carry_normalize_stream: RTL and testbench
=========================================

Name: carry_normalize_stream

Overview:
- Parametrised successor to the single-pair CIOS normalize PE.
- Streams an NUM_WORDS-word partial-product vector T[0..N-1], one word per beat, and injects a word-wide carry-in at T[0].
- Ripples the carry through every word and emits the normalized vector plus the final carry.
- Sits between the CIOS multiply/reduce loop and the result buffer; valid/ready on both sides, one beat per cycle sustained.

Parameters:
WORD_WIDTH, 32, width of each data word and of the carry-in
NUM_WORDS, 8, words per vector (>=2)
EMIT_CARRY_WORD, 1, 1: final carry sent as an extra word N; 0: final carry on out_carry sideband with last data word

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cin  in  WORD_WIDTH  carry-in word, sampled only on the first beat of a vector
in_data  in  WORD_WIDTH  T[i]
in_valid  in  1  input beat valid
in_last  in  1  marks T[N-1]
in_ready  out  1  block can accept a beat
out_data  out  WORD_WIDTH  normalized word
out_idx  out  $clog2(NUM_WORDS+1)  index of out_data within the vector
out_carry  out  1  final carry (valid with out_last when EMIT_CARRY_WORD=0, else 0)
out_last  out  1  last beat of the output vector
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
len_err  out  1  one-cycle pulse: in_last disagreed with word count
busy  out  1  vector in flight (state != IDLE or out_valid)

Behaviour:
- Reset (synchronous, active-high; clock clk): state=IDLE, carry=0, idx=0, out_valid=0, out_data=0, out_idx=0, out_last=0, out_carry=0, len_err=0. Reset mid-vector discards all in-flight data; no output beat follows.
- Transfer occurs on valid&&ready (either side). A single output register holds the result; free = !out_valid || out_ready.
- in_ready = free && state in {IDLE, RUN}.
- States:
  - IDLE: on an input transfer, sum = in_data + cin (WORD_WIDTH+1 bits). Go to RUN, or to END_CHECK handling if the vector terminates on this beat.
  - RUN: on an input transfer, sum = in_data + carry.
  - CARRY: emit the extra carry word.
- Carry register is WORD_WIDTH wide; it is loaded with zero-extended sum[WORD_WIDTH]. After beat 0 it is 0 or 1.
- Each accepted beat loads the output register on the same edge: out_data = sum[W-1:0], out_idx = idx; idx increments.
- Latency: input beat at edge n is visible on out_* after edge n (1 cycle).
- Vector termination: the accepted beat with in_last=1 OR idx==NUM_WORDS-1, whichever comes first.
  - If exactly one of the two holds, len_err pulses 1 cycle after that beat.
  - The vector is terminated anyway; a short vector's carry still completes.
- On termination:
  - EMIT_CARRY_WORD=1: that data beat has out_last=0, and the state goes to CARRY. In CARRY, in_ready=0. When free, the output loads out_data = final carry (zero-extended), out_idx = terminating idx+1, out_last=1. The state then returns to IDLE.
  - EMIT_CARRY_WORD=0: that data beat has out_last=1 and out_carry = sum[W]. The state goes directly to IDLE, so the next vector's first beat can be accepted next cycle.
- Backpressure: while out_valid && !out_ready, the output register and carry hold and in_ready=0. in_data/cin are not consumed.
- After termination, idx and carry clear to 0, so back-to-back vectors are independent.
- cin is ignored on all beats except the first of a vector.
- Full throughput: with out_ready=1, N-word vectors take N+1 cycles (EMIT=1) or N cycles (EMIT=0).

Decomposition:
- Package cios_pkg:
  - norm_state_t enum {IDLE, RUN, CARRY}
  - word_t typedef (logic [WORD_WIDTH-1:0])
  - idx width function clog2(NUM_WORDS+1)
- Sub-module carry_add_stage: combinational WORD_WIDTH+1 adder, (a, b) -> {cout, sum}. It is reused by the future multi-lane normalizer.

Test Plan:
- W=32, N=4, EMIT=1: cin=0x1, T={FFFFFFFF, FFFFFFFF, FFFFFFFF, 00000005}, out_ready=1. Expect out={0, 0, 0, 00000006, 00000000}, idx 0..4, out_last only on idx 4, len_err=0.
- cin=FFFFFFFF, T={FFFFFFFF, FFFFFFFF, FFFFFFFF, FFFFFFFF}. Expect out={FFFFFFFE, 0, 0, 0, 00000001}.
- EMIT=0, same first stimulus. Expect 4 beats, out_last with idx 3, out_carry=0. Next vector accepted the following cycle.
- Backpressure: toggle out_ready 1,0,0,1,... during vector 1. Expect the output to hold stable while stalled, in_ready=0 while stalled, and identical data to the no-stall run.
- in_last asserted on beat 2 (N=4). Expect termination with carry word at idx 3 and a len_err pulse. Next vector starts at idx 0 with cin honoured.
- Assert rst while in RUN after beat 1. Expect out_valid=0 next cycle, busy=0, and no further out beats. The next vector's output matches the golden model.

Source files
------------

// File: rtl/carry_normalize_stream_pkg.sv
// carry_normalize_stream_pkg
// Shared types and helpers for the carry-normalize stream and its adder stage.
//   norm_state_t : normalizer control states
//   word_t       : default-width data word (32 bits)
//   idx_width()  : width of an index that can count 0..n inclusive
package carry_normalize_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CARRY = 2'd2
  } norm_state_t;

  localparam int DEFAULT_WORD_WIDTH = 32;

  typedef logic [DEFAULT_WORD_WIDTH-1:0] word_t;

  // The extra carry word sits at index NUM_WORDS, so the index must reach n.
  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/carry_normalize_stream_if.sv
// carry_normalize_stream_if
// Input and output valid/ready streams of the carry normalizer.
//   Input side : cin, in_data, in_valid, in_last -> in_ready
//   Output side: out_data, out_idx, out_carry, out_last, out_valid <- out_ready
// Modports: slave = normalizer side, master = producer/consumer side.
interface carry_normalize_stream_if
  import carry_normalize_stream_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_WORDS  = 8
);
  localparam int IDX_W = idx_width(NUM_WORDS);

  logic [WORD_WIDTH-1:0] cin;
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]      out_idx;
  logic                  out_carry;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  cin, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_idx, out_carry, out_last, out_valid
  );

  modport master (
    output cin, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_idx, out_carry, out_last, out_valid
  );

endinterface

// File: rtl/carry_normalize_stream_add.sv
// carry_add_stage
// Combinational WORD_WIDTH+1 bit adder: {cout, sum} = a + b.
//   a, b : operands (WORD_WIDTH)
//   sum  : low WORD_WIDTH bits of the result
//   cout : carry out of the top bit
module carry_add_stage #(
  parameter int WORD_WIDTH = 32
) (
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  output logic [WORD_WIDTH-1:0] sum,
  output logic                  cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/carry_normalize_stream.sv
// carry_normalize_stream
// Ripples a word-wide carry-in through an NUM_WORDS-word partial-product
// vector, one word per beat, and emits the normalized words plus the final
// carry (as an extra word, or as a sideband bit on the last data word).
//   clk, rst : clock, synchronous active-high reset
//   bus      : input/output valid/ready streams (slave modport)
//   len_err  : one-cycle pulse when in_last and the word count disagree
//   busy     : vector in flight or output beat pending
module carry_normalize_stream
  import carry_normalize_stream_pkg::*;
#(
  parameter int WORD_WIDTH      = 32,
  parameter int NUM_WORDS       = 8,
  parameter bit EMIT_CARRY_WORD = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  carry_normalize_stream_if.slave         bus,
  output logic                            len_err,
  output logic                            busy
);

  localparam int IW = idx_width(NUM_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  norm_state_t           state_q, state_d;
  logic [WORD_WIDTH-1:0] carry_q, carry_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
  logic [IW-1:0]         out_idx_q, out_idx_d;
  logic                  out_carry_q, out_carry_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
  logic                  len_err_q, len_err_d;

  logic                  free;
  logic                  in_fire;
  logic                  at_count_end;
  logic                  term;
  logic [WORD_WIDTH-1:0] add_b;
  logic [WORD_WIDTH-1:0] add_sum;
  logic                  add_cout;

  assign free         = !out_valid_q || bus.out_ready;
  assign bus.in_ready = free && (state_q != CARRY);
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign at_count_end = (idx_q == LAST_IDX);
  assign term         = bus.in_last || at_count_end;

  // cin only enters on the first beat; later beats add the rippled carry.
  assign add_b = (state_q == IDLE) ? bus.cin : carry_q;

  carry_add_stage #(.WORD_WIDTH(WORD_WIDTH)) u_add (
    .a    (bus.in_data),
    .b    (add_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_carry_d = out_carry_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    len_err_d   = 1'b0;

    unique case (state_q)
      IDLE, RUN: begin
        if (in_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = add_sum;
          out_idx_d   = idx_q;
          out_last_d  = 1'b0;
          out_carry_d = 1'b0;
          len_err_d   = bus.in_last ^ at_count_end;
          if (term) begin
            if (EMIT_CARRY_WORD) begin
              // idx advances so the carry word lands at terminating idx+1.
              state_d = CARRY;
              carry_d = {{(WORD_WIDTH-1){1'b0}}, add_cout};
              idx_d   = idx_q + IW'(1);
            end else begin
              out_last_d  = 1'b1;
              out_carry_d = add_cout;
              state_d     = IDLE;
              carry_d     = '0;
              idx_d       = '0;
            end
          end else begin
            state_d = RUN;
            carry_d = {{(WORD_WIDTH-1){1'b0}}, add_cout};
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      CARRY: begin
        if (free) begin
          out_valid_d = 1'b1;
          out_data_d  = carry_q;
          out_idx_d   = idx_q;
          out_last_d  = 1'b1;
          out_carry_d = 1'b0;
          state_d     = IDLE;
          carry_d     = '0;
          idx_d       = '0;
        end
      end
      default: begin
        state_d = IDLE;
        carry_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      carry_q     <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_carry_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_carry_q <= out_carry_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      len_err_q   <= len_err_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_carry = out_carry_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;
  assign len_err       = len_err_q;
  assign busy          = (state_q != IDLE) || out_valid_q;

endmodule

// File: tb/tb_carry_normalize_stream.sv
// tb_carry_normalize_stream
// Drives two normalizers (carry-word and sideband variants, W=32, N=4) from
// one stimulus source, selected by sel, and checks every output transfer
// against a whole-vector arithmetic model.
module tb_carry_normalize_stream;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 3;
  localparam int BW = W * (N + 1);

  typedef struct packed {
    logic [W-1:0]  data;
    logic [IW-1:0] idx;
    logic          last;
    logic          carry;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         sel = 1'b1;
  logic [W-1:0] cin = '0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b1;
  int           rdy_mode = 0;
  int           rdy_phase = 0;

  carry_normalize_stream_if #(.WORD_WIDTH(W), .NUM_WORDS(N)) if1 ();
  carry_normalize_stream_if #(.WORD_WIDTH(W), .NUM_WORDS(N)) if0 ();

  assign if1.cin       = cin;
  assign if1.in_data   = in_data;
  assign if1.in_last   = in_last;
  assign if1.in_valid  = in_valid && sel;
  assign if1.out_ready = out_ready;
  assign if0.cin       = cin;
  assign if0.in_data   = in_data;
  assign if0.in_last   = in_last;
  assign if0.in_valid  = in_valid && !sel;
  assign if0.out_ready = out_ready;

  logic len_err1, busy1, len_err0, busy0;

  carry_normalize_stream #(.WORD_WIDTH(W), .NUM_WORDS(N), .EMIT_CARRY_WORD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .len_err(len_err1), .busy(busy1));
  carry_normalize_stream #(.WORD_WIDTH(W), .NUM_WORDS(N), .EMIT_CARRY_WORD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .len_err(len_err0), .busy(busy0));

  logic  in_ready_m, out_valid_m, len_err_m, busy_m;
  beat_t cur;
  always_comb begin
    if (sel) begin
      in_ready_m  = if1.in_ready;
      out_valid_m = if1.out_valid;
      len_err_m   = len_err1;
      busy_m      = busy1;
      cur         = {if1.out_data, if1.out_idx, if1.out_last, if1.out_carry};
    end else begin
      in_ready_m  = if0.in_ready;
      out_valid_m = if0.out_valid;
      len_err_m   = len_err0;
      busy_m      = busy0;
      cur         = {if0.out_data, if0.out_idx, if0.out_last, if0.out_carry};
    end
  end

  int errors = 0;
  int checks = 0;
  int len_err_exp = 0;
  int len_err_seen = 0;
  int cyc = 0;
  beat_t exp_q[$];
  beat_t mq[$];
  logic [W-1:0] tv[N];

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: 0 = always ready, 1 = random, 2 = pattern 1,0,0,1...
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: out_ready = ($urandom_range(0, 2) != 0);
      2: begin
        out_ready = (rdy_phase == 0) || (rdy_phase == 3);
        rdy_phase = (rdy_phase + 1) % 4;
      end
      default: out_ready = 1'b1;
    endcase
  end

  // Compare process: every output transfer is popped from the expected queue.
  bit    stalled = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (len_err_m) len_err_seen++;
      if (stalled) begin
        checks++;
        if (out_valid_m !== 1'b1 || cur !== held) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b beat=%h, want valid=1 beat=%h", out_valid_m, cur, held);
        end
      end
      if (out_valid_m && !out_ready) begin
        checks++;
        if (in_ready_m !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: got %b, want 0", in_ready_m);
        end
      end
      if (out_valid_m && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data=%h idx=%0d, want no beat", cur.data, cur.idx);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL beat: got data=%h idx=%0d last=%b carry=%b, want data=%h idx=%0d last=%b carry=%b",
                     cur.data, cur.idx, cur.last, cur.carry, e.data, e.idx, e.last, e.carry);
          end
        end
      end
      stalled = out_valid_m && !out_ready;
      held = cur;
    end
  end

  // Whole-vector model: T as one big integer plus cin; words are its slices.
  function automatic bit model(input logic [W-1:0] c, input int last_pos, input bit emit);
    logic [BW-1:0] big;
    logic [W-1:0]  cw;
    int            tend;
    beat_t         b;
    mq.delete();
    tend = (last_pos < N - 1) ? last_pos : N - 1;
    big = BW'(c);
    for (int i = 0; i <= tend; i++) big = big + (BW'(tv[i]) << (W * i));
    cw = big[W*(tend+1) +: W];
    for (int i = 0; i <= tend; i++) begin
      b.data  = big[W*i +: W];
      b.idx   = IW'(i);
      b.last  = !emit && (i == tend);
      b.carry = !emit && (i == tend) && cw[0];
      mq.push_back(b);
    end
    if (emit) begin
      b.data  = cw;
      b.idx   = IW'(tend + 1);
      b.last  = 1'b1;
      b.carry = 1'b0;
      mq.push_back(b);
    end
    return (last_pos == tend) != (tend == N - 1);
  endfunction

  task automatic drive_beat(input logic [W-1:0] d, input logic [W-1:0] c, input bit l, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = -1;
    in_valid = 1'b1;
    in_data  = d;
    cin      = c;
    in_last  = l;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready_m) begin
        ok = 1'b1;
        acc_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, want 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // last_pos >= N means in_last never asserted; abort_after >= 0 stops early.
  task automatic send_vec(input logic [W-1:0] c, input int last_pos, input int abort_after, output int first_cyc);
    bit lerr;
    int tend, nb, ac;
    lerr = model(c, last_pos, sel);
    tend = (last_pos < N - 1) ? last_pos : N - 1;
    if (abort_after >= 0) begin
      nb = abort_after + 1;
      for (int i = 0; i < nb; i++) exp_q.push_back(mq[i]);
    end else begin
      nb = tend + 1;
      foreach (mq[i]) exp_q.push_back(mq[i]);
      if (lerr) len_err_exp++;
    end
    first_cyc = -1;
    for (int i = 0; i < nb; i++) begin
      drive_beat(tv[i], (i == 0) ? c : W'($urandom), (i == last_pos), ac);
      if (i == 0) first_cyc = ac;
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy_m && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got busy=%b pending=%0d, want idle", busy_m, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic load_a();
    tv[0] = 32'hFFFF_FFFF; tv[1] = 32'hFFFF_FFFF; tv[2] = 32'hFFFF_FFFF; tv[3] = 32'h0000_0005;
  endtask

  task automatic load_b();
    for (int i = 0; i < N; i++) tv[i] = 32'hFFFF_FFFF;
  endtask

  task automatic load_rand();
    for (int i = 0; i < N; i++) tv[i] = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : W'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, le0;
    bit lerr;
    logic [W-1:0] pin_a[5] = '{32'h0, 32'h0, 32'h0, 32'h6, 32'h0};
    logic [W-1:0] pin_b[5] = '{32'hFFFF_FFFE, 32'h0, 32'h0, 32'h0, 32'h1};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_out_valid1", if1.out_valid, 0);
    check_val("rst_out_valid0", if0.out_valid, 0);
    check_val("rst_busy1", busy1, 0);
    check_val("rst_len_err1", len_err1, 0);
    check_val("rst_out_data1", if1.out_data, 0);
    check_val("rst_in_ready1", if1.in_ready, 1);
    @(posedge clk);
    #1;

    // Pin the model itself to hand-computed results.
    load_a();
    lerr = model(32'h1, N - 1, 1'b1);
    check_val("pin_a_len", mq.size(), 5);
    check_val("pin_a_lerr", lerr, 0);
    for (int i = 0; i < 5; i++) check_val("pin_a_data", mq[i].data, pin_a[i]);
    check_val("pin_a_last", mq[4].last, 1);
    check_val("pin_a_idx", mq[4].idx, 4);
    load_b();
    lerr = model(32'hFFFF_FFFF, N - 1, 1'b1);
    for (int i = 0; i < 5; i++) check_val("pin_b_data", mq[i].data, pin_b[i]);
    load_a();
    lerr = model(32'h1, N - 1, 1'b0);
    check_val("pin_a0_len", mq.size(), 4);
    check_val("pin_a0_last", mq[3].last, 1);
    check_val("pin_a0_carry", mq[3].carry, 0);
    load_a();
    lerr = model(32'h1, 2, 1'b1);
    check_val("pin_short_lerr", lerr, 1);
    check_val("pin_short_cidx", mq[3].idx, 3);
    check_val("pin_short_cw", mq[3].data, 1);

    // Carry-word variant: directed vectors back to back, full throughput.
    sel = 1'b1;
    rdy_mode = 0;
    load_a();
    send_vec(32'h1, N - 1, -1, c1);
    load_b();
    send_vec(32'hFFFF_FFFF, N - 1, -1, c2);
    check_val("tput_emit1", c2 - c1, N + 1);
    drain();

    // Sideband variant.
    sel = 1'b0;
    load_a();
    send_vec(32'h1, N - 1, -1, c1);
    load_b();
    send_vec(32'hFFFF_FFFF, N - 1, -1, c2);
    check_val("tput_emit0", c2 - c1, N);
    drain();
    check_val("len_err_directed", len_err_seen, len_err_exp);

    // Backpressure 1,0,0,1 on the first vector.
    sel = 1'b1;
    rdy_mode = 2;
    load_a();
    send_vec(32'h1, N - 1, -1, c1);
    drain();

    // Early in_last, then a normal vector with cin honoured.
    rdy_mode = 0;
    le0 = len_err_seen;
    load_a();
    send_vec(32'h1, 2, -1, c1);
    drain();
    check_val("len_err_short", len_err_seen - le0, 1);
    load_rand();
    send_vec(32'h1234_5678, N - 1, -1, c1);
    load_rand();
    send_vec(32'hFFFF_FFFF, N, -1, c1);
    drain();
    check_val("len_err_missing_last", len_err_seen - le0, 2);

    // Reset in RUN after beat 1.
    load_a();
    send_vec(32'h1, N - 1, 1, c1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("abort_out_valid", if1.out_valid, 0);
    check_val("abort_busy", busy1, 0);
    @(posedge clk);
    #1;
    repeat (4) @(posedge clk);
    #1;
    load_b();
    send_vec(32'hFFFF_FFFF, N - 1, -1, c1);
    drain();

    // Randomized vectors with random backpressure on both variants.
    for (int s = 0; s < 2; s++) begin
      sel = (s == 0);
      rdy_mode = 1;
      for (int v = 0; v < 25; v++) begin
        load_rand();
        send_vec(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : W'($urandom),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N)) : N - 1, -1, c1);
      end
      rdy_mode = 0;
      drain();
    end

    check_val("len_err_total", len_err_seen, len_err_exp);
    check_val("final_idle", busy1 | busy0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
